// File: rtl/wb_sram_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin selection at cycle boundaries.
// The registered grant steers purely combinational muxes, so a granted master sees no added latency.
`timescale 1ns/1ps
module wb_sram_arbiter #(
   parameter int WIDTH = 8,
   parameter int SBITS = 12,
   parameter int DELAY = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             m0_cyc_i,
   input  logic             m0_stb_i,
   input  logic             m0_we_i,
   input  logic             m0_bst_i,
   output logic             m0_ack_o,
   input  logic [SBITS-1:0] m0_adr_i,
   input  logic [WIDTH-1:0] m0_dat_i,
   output logic [WIDTH-1:0] m0_dat_o,
   input  logic             m1_cyc_i,
   input  logic             m1_stb_i,
   input  logic             m1_we_i,
   input  logic             m1_bst_i,
   output logic             m1_ack_o,
   input  logic [SBITS-1:0] m1_adr_i,
   input  logic [WIDTH-1:0] m1_dat_i,
   output logic [WIDTH-1:0] m1_dat_o,
   output logic             s_cyc_o,
   output logic             s_stb_o,
   output logic             s_we_o,
   output logic             s_bst_o,
   input  logic             s_ack_i,
   output logic [SBITS-1:0] s_adr_o,
   output logic [WIDTH-1:0] s_dat_o,
   input  logic [WIDTH-1:0] s_dat_i,
   output logic [1:0]       gnt_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   state_t w_arb;
   logic   r_last;
   logic   w_last_nxt;

   // Registered state updates are zero-delay here; the parameter only has to be non-negative.
   if (DELAY < 0) begin : g_delay_range
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
      end
   end

   // Contention goes to whichever master was not granted most recently.
   always_comb begin
      w_arb = IDLE;
      if (m0_cyc_i && m1_cyc_i) begin
         w_arb = r_last ? GNT0 : GNT1;
      end else if (m0_cyc_i) begin
         w_arb = GNT0;
      end else if (m1_cyc_i) begin
         w_arb = GNT1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      case (r_state)
         IDLE:    w_state_nxt = w_arb;
         GNT0:    if (!m0_cyc_i) w_state_nxt = w_arb;
         GNT1:    if (!m1_cyc_i) w_state_nxt = w_arb;
         default: w_state_nxt = IDLE;
      endcase
      if (w_state_nxt == GNT0) begin
         w_last_nxt = 1'b0;
      end else if (w_state_nxt == GNT1) begin
         w_last_nxt = 1'b1;
      end
   end

   // Address/data default to master 0 so they stay stable while idle.
   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_bst_o  = 1'b0;
      s_adr_o  = m0_adr_i;
      s_dat_o  = m0_dat_i;
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
      case (r_state)
         GNT0: begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_bst_o  = m0_bst_i;
            m0_ack_o = s_ack_i;
         end
         GNT1: begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_bst_o  = m1_bst_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            m1_ack_o = s_ack_i;
         end
         default: begin
         end
      endcase
   end

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign gnt_o    = {r_state == GNT1, r_state == GNT0};

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Directed bench for wb_sram_arbiter: two bus-master tasks, a one-cycle-ack SRAM slave and a
// per-cycle trace of grant/cycle/ack used to check grant ordering, gaps and burst integrity.
`timescale 1ns/1ps
module tb_wb_sram_arbiter;
   localparam int WIDTH = 8;
   localparam int SBITS = 12;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic             m_cyc  [2];
   logic             m_stb  [2];
   logic             m_we   [2];
   logic             m_bst  [2];
   logic [SBITS-1:0] m_adr  [2];
   logic [WIDTH-1:0] m_wdat [2];
   logic             m0_ack, m1_ack;
   logic [WIDTH-1:0] m0_rdat, m1_rdat;
   logic             s_cyc, s_stb, s_we, s_bst, s_ack;
   logic [SBITS-1:0] s_adr;
   logic [WIDTH-1:0] s_wdat, s_rdat;
   logic [1:0]       gnt;

   wb_sram_arbiter #(.WIDTH(WIDTH), .SBITS(SBITS), .DELAY(3)) dut (
      .clk_i(clk), .rst_i(rst),
      .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_bst_i(m_bst[0]),
      .m0_ack_o(m0_ack), .m0_adr_i(m_adr[0]), .m0_dat_i(m_wdat[0]), .m0_dat_o(m0_rdat),
      .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_bst_i(m_bst[1]),
      .m1_ack_o(m1_ack), .m1_adr_i(m_adr[1]), .m1_dat_i(m_wdat[1]), .m1_dat_o(m1_rdat),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_bst_o(s_bst), .s_ack_i(s_ack),
      .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .gnt_o(gnt)
   );

   // SRAM slave: acks one cycle after a strobe is seen, one beat per two cycles.
   logic [WIDTH-1:0] mem [0:(1<<SBITS)-1];
   logic             slv_ack;
   logic             force_ack;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         slv_ack <= 1'b0;
      end else if (s_cyc && s_stb && !slv_ack) begin
         slv_ack <= 1'b1;
         if (s_we) mem[s_adr] <= s_wdat;
         else      s_rdat     <= mem[s_adr];
      end else begin
         slv_ack <= 1'b0;
      end
   end
   assign s_ack = slv_ack | force_ack;

   logic [1:0] tr_gnt [$];
   bit         tr_cyc [$];
   bit         tr_a0  [$];
   bit         tr_a1  [$];
   always @(negedge clk) begin
      tr_gnt.push_back(gnt);
      tr_cyc.push_back(s_cyc);
      tr_a0.push_back(m0_ack);
      tr_a1.push_back(m1_ack);
   end

   int n_chk = 0;
   int n_err = 0;
   logic [WIDTH-1:0] exp_mem [0:(1<<SBITS)-1];
   int beats [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic wait_ack(input int m, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if ((m == 0) ? m0_ack : m1_ack) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic mtx(input int m, input bit we, input logic [SBITS-1:0] a, input int n,
                      input logic [WIDTH-1:0] wbase);
      bit ok;
      logic [WIDTH-1:0] got;
      beats[m] = 0;
      @(posedge clk); #1;
      m_cyc[m] = 1'b1;
      m_stb[m] = 1'b1;
      m_we[m]  = we;
      m_bst[m] = (n > 1);
      for (int b = 0; b < n; b++) begin
         m_adr[m]  = a + SBITS'(b);
         m_wdat[m] = wbase + WIDTH'(b);
         wait_ack(m, ok);
         if (!ok) break;
         chk("s_adr", 32'(s_adr), 32'(m_adr[m]));
         chk("s_we", 32'(s_we), 32'(m_we[m]));
         chk("s_bst", 32'(s_bst), 32'(m_bst[m]));
         if (we) begin
            exp_mem[m_adr[m]] = m_wdat[m];
         end else begin
            got = (m == 0) ? m0_rdat : m1_rdat;
            chk("rdata", 32'(got), 32'(exp_mem[m_adr[m]]));
         end
         beats[m] = b + 1;
         @(posedge clk); #1;
      end
      m_cyc[m] = 1'b0;
      m_stb[m] = 1'b0;
      m_we[m]  = 1'b0;
      m_bst[m] = 1'b0;
   endtask

   // Split the trace into bus cycles: each run is a stretch with s_cyc high.
   int n_runs;
   int run_gnt [16];
   int run_gap [16];
   int run_a0  [16];
   int run_a1  [16];
   int run_chg [16];

   task automatic analyze(input int from);
      int gap;
      bit prev;
      int r;
      gap = 0;
      prev = 1'b0;
      n_runs = 0;
      for (int i = from; i < tr_cyc.size(); i++) begin
         if (tr_cyc[i]) begin
            if (!prev && n_runs < 16) begin
               run_gnt[n_runs] = int'(tr_gnt[i]);
               run_gap[n_runs] = gap;
               run_a0[n_runs]  = 0;
               run_a1[n_runs]  = 0;
               run_chg[n_runs] = 0;
               n_runs++;
               gap = 0;
            end
            r = n_runs - 1;
            if (r >= 0) begin
               run_a0[r] += int'(tr_a0[i]);
               run_a1[r] += int'(tr_a1[i]);
               if (int'(tr_gnt[i]) != run_gnt[r]) run_chg[r]++;
            end
         end else begin
            gap++;
         end
         prev = tr_cyc[i];
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "bench did not finish");
   end

   initial begin
      bit ok;
      int from;
      bit seen;
      force_ack = 1'b0;
      for (int m = 0; m < 2; m++) begin
         m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0; m_bst[m] = 1'b0;
         m_adr[m] = '0; m_wdat[m] = '0; beats[m] = 0;
      end
      // Reset holds every control output low even with a master requesting.
      rst = 1'b1;
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
      #12;
      chk("rst_scyc", 32'(s_cyc), 32'd0);
      chk("rst_sstb", 32'(s_stb), 32'd0);
      chk("rst_swe", 32'(s_we), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_ack", 32'({m1_ack, m0_ack}), 32'd0);
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_we[0] = 1'b0;
      #11 rst = 1'b0;

      // Single master write on an idle bus.
      @(posedge clk); #1;
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_bst[0] = 1'b0;
      m_adr[0] = 12'h123; m_wdat[0] = 8'hA5;
      @(negedge clk);
      chk("t1_gnt_pre", 32'(gnt), 32'd0);
      @(negedge clk);
      chk("t1_gnt", 32'(gnt), 32'd1);
      chk("t1_scyc", 32'(s_cyc), 32'd1);
      wait_ack(0, ok);
      chk("t1_m1ack", 32'(m1_ack), 32'd0);
      exp_mem[12'h123] = 8'hA5;
      @(posedge clk); #1;
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_we[0] = 1'b0;
      @(negedge clk);
      chk("t1_gnt_hold", 32'(gnt), 32'd1);
      chk("t1_scyc_gap", 32'(s_cyc), 32'd0);
      @(negedge clk);
      chk("t1_gnt_idle", 32'(gnt), 32'd0);
      chk("t1_mem", 32'(mem[12'h123]), 32'hA5);

      // Simultaneous reads: m0 first, one idle bus cycle, then m1.
      mtx(0, 1'b1, 12'h010, 1, 8'h3C);
      mtx(1, 1'b1, 12'h020, 1, 8'hC3);
      from = tr_cyc.size();
      fork
         mtx(0, 1'b0, 12'h010, 1, 8'h00);
         mtx(1, 1'b0, 12'h020, 1, 8'h00);
      join
      repeat (2) @(posedge clk);
      analyze(from);
      chk("t2_runs", 32'(n_runs), 32'd2);
      if (n_runs >= 2) begin
         chk("t2_first", 32'(run_gnt[0]), 32'd1);
         chk("t2_second", 32'(run_gnt[1]), 32'd2);
         chk("t2_gap", 32'(run_gap[1]), 32'd1);
      end

      // Round-robin with both masters requesting back to back.
      from = tr_cyc.size();
      fork
         begin
            mtx(0, 1'b1, 12'h200, 2, 8'h10);
            mtx(0, 1'b1, 12'h210, 2, 8'h20);
         end
         begin
            mtx(1, 1'b1, 12'h300, 2, 8'h30);
            mtx(1, 1'b1, 12'h310, 2, 8'h40);
         end
      join
      repeat (2) @(posedge clk);
      analyze(from);
      chk("t3_runs", 32'(n_runs), 32'd4);
      if (n_runs >= 4) begin
         for (int r = 0; r < 4; r++) begin
            chk("t3_gnt", 32'(run_gnt[r]), (r % 2 == 0) ? 32'd1 : 32'd2);
            chk("t3_acks", 32'(run_a0[r] + run_a1[r]), 32'd2);
            if (r > 0) chk("t3_gap", 32'(run_gap[r]), 32'd1);
         end
      end

      // 16-beat burst by m1 is not split when m0 requests mid-burst.
      from = tr_cyc.size();
      beats[1] = 0;
      fork
         mtx(1, 1'b1, 12'h7F0, 16, 8'h80);
         begin
            seen = 1'b0;
            for (int k = 0; k < 200; k++) begin
               @(negedge clk);
               if (beats[1] >= 3) begin
                  seen = 1'b1;
                  break;
               end
            end
            chk("t4_beat3", 32'(seen), 32'd1);
            mtx(0, 1'b0, 12'h7F0, 1, 8'h00);
         end
      join
      repeat (2) @(posedge clk);
      analyze(from);
      chk("t4_runs", 32'(n_runs), 32'd2);
      if (n_runs >= 2) begin
         chk("t4_gnt1", 32'(run_gnt[0]), 32'd2);
         chk("t4_beats", 32'(run_a1[0]), 32'd16);
         chk("t4_m0ack", 32'(run_a0[0]), 32'd0);
         chk("t4_nochg", 32'(run_chg[0]), 32'd0);
         chk("t4_gnt0", 32'(run_gnt[1]), 32'd1);
         chk("t4_m0beat", 32'(run_a0[1]), 32'd1);
      end
      mtx(1, 1'b0, 12'h7F0, 16, 8'h00);
      repeat (2) @(posedge clk);

      // A stray slave ack on an idle bus goes nowhere.
      @(posedge clk); #1;
      force_ack = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t5_ack", 32'({m1_ack, m0_ack}), 32'd0);
         chk("t5_gnt", 32'(gnt), 32'd0);
      end
      @(posedge clk); #1;
      force_ack = 1'b0;

      // Asynchronous reset in the fifth beat of an 8-beat m0 read.
      @(posedge clk); #1;
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_bst[0] = 1'b1;
      for (int b = 0; b < 8; b++) begin
         m_adr[0] = 12'h7F0 + SBITS'(b);
         if (b == 4) begin
            #3 rst = 1'b1;
            #1;
            chk("t6_scyc", 32'(s_cyc), 32'd0);
            chk("t6_gnt", 32'(gnt), 32'd0);
            chk("t6_ack", 32'(m0_ack), 32'd0);
            break;
         end
         wait_ack(0, ok);
         if (!ok) break;
         @(posedge clk); #1;
      end
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_bst[0] = 1'b0;
      #13 rst = 1'b0;
      from = tr_cyc.size();
      fork
         mtx(0, 1'b1, 12'h400, 1, 8'h11);
         mtx(1, 1'b1, 12'h401, 1, 8'h22);
      join
      repeat (2) @(posedge clk);
      analyze(from);
      chk("t6_runs", 32'(n_runs), 32'd2);
      if (n_runs >= 2) begin
         chk("t6_first", 32'(run_gnt[0]), 32'd1);
         chk("t6_second", 32'(run_gnt[1]), 32'd2);
      end
      chk("t6_mem0", 32'(mem[12'h400]), 32'h11);
      chk("t6_mem1", 32'(mem[12'h401]), 32'h22);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
